// File: rtl/cube_if.sv
// Handshake bundle for the sequential cube unit: operand, start request,
// busy flag and 24-bit result.
interface cube_if;
   logic [7:0]  a_bi;
   logic        start_i;
   logic        busy_o;
   logic [23:0] y_bo;

   modport master (output a_bi, output start_i, input busy_o, input y_bo);
   modport slave  (input a_bi, input start_i, output busy_o, output y_bo);
endinterface

// File: rtl/cube.sv
// Sequential cube unit: y = a*a*a using a 1-bit-per-cycle shift-add multiplier run twice.
// Optional macro CUBE_EARLY_EXIT_EN ends each multiply phase once the multiplier runs out of set bits.
module cube (
   input  logic   clk_i,
   input  logic   rst_i,
   cube_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SQUARE, CUBE, DONE} state_t;

   state_t      state;
   logic        busy;
   logic [23:0] y;
   logic [7:0]  x;
   logic [7:0]  m;
   // The second pass shifts a 16-bit square up to 7 places, so md spans 24 bits.
   logic [23:0] md;
   logic [23:0] acc;
   logic [23:0] acc_add;
   logic        last_iter;

   assign acc_add = m[0] ? (acc + md) : acc;

`ifdef CUBE_EARLY_EXIT_EN
   assign last_iter = (m[7:1] == 7'd0);
`else
   logic [3:0]  cnt;
   assign last_iter = (cnt == 4'd7);
`endif

   assign bus.busy_o = busy;
   assign bus.y_bo   = y;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         busy  <= 1'b0;
         y     <= 24'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  x     <= bus.a_bi;
                  m     <= bus.a_bi;
                  md    <= {16'd0, bus.a_bi};
                  acc   <= 24'd0;
`ifndef CUBE_EARLY_EXIT_EN
                  cnt   <= 4'd0;
`endif
                  y     <= 24'd0;
                  busy  <= 1'b1;
                  state <= SQUARE;
               end
            end
            SQUARE, CUBE: begin
               acc <= acc_add;
               md  <= md << 1;
               m   <= m >> 1;
`ifndef CUBE_EARLY_EXIT_EN
               cnt <= cnt + 4'd1;
`endif
               if (last_iter) begin
                  if (state == SQUARE) begin
                     // Square becomes the multiplicand for the second pass.
                     m     <= x;
                     md    <= {8'd0, acc_add[15:0]};
                     acc   <= 24'd0;
`ifndef CUBE_EARLY_EXIT_EN
                     cnt   <= 4'd0;
`endif
                     state <= CUBE;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               y     <= acc;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cube.sv
// Self-checking bench for cube: directed scenarios plus an exhaustive and a
// randomized operand sweep against an arithmetic a^3 / latency model.
module tb_cube;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   checks = 0;
   int   errors = 0;

   cube_if bus();

   cube dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   int unsigned cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] ref_cube(input int a);
      return 32'(a * a * a);
   endfunction

   // Cycles busy stays high after an accepted start.
   function automatic logic [31:0] ref_lat(input int a);
`ifdef CUBE_EARLY_EXIT_EN
      int n;
      n = (a == 0) ? 0 : $clog2(a + 1);
      if (n < 1) n = 1;
      return 32'(2 * n + 1);
`else
      return 32'd17;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Present an operand with start high; returns #1 after the acceptance edge.
   task automatic start_op(input logic [7:0] a);
      @(negedge clk_i);
      bus.a_bi    = a;
      bus.start_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   // Counts edges until busy falls (bounded); also notes whether y stayed 0.
   task automatic wait_done(output int lat, output bit y_zero);
      lat    = 0;
      y_zero = 1'b1;
      while (bus.busy_o === 1'b1 && lat < 40) begin
         if (bus.y_bo !== 24'd0) y_zero = 1'b0;
         lat++;
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic do_op(input logic [7:0] a, input string tag);
      int lat;
      bit yz;
      start_op(a);
      bus.start_i = 1'b0;
      check($sformatf("%s_busy_a%0d", tag, a), 32'(bus.busy_o), 32'd1);
      wait_done(lat, yz);
      check($sformatf("%s_lat_a%0d", tag, a), 32'(lat), ref_lat(a));
      check($sformatf("%s_yzero_a%0d", tag, a), 32'(yz), 32'd1);
      check($sformatf("%s_y_a%0d", tag, a), 32'(bus.y_bo), ref_cube(a));
   endtask

   initial begin
      int lat;
      bit yz;
      int unsigned k1;
      int unsigned k2;
      logic [7:0] ra;

      bus.a_bi    = 8'd0;
      bus.start_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_busy", 32'(bus.busy_o), 32'd0);
      check("reset_y", 32'(bus.y_bo), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      do_op(8'd0, "zero");
      do_op(8'd5, "five");
      do_op(8'd255, "max");

      // Start during busy is ignored, then accepted once IDLE is reached.
      start_op(8'd7);
      bus.start_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      bus.a_bi    = 8'd9;
      bus.start_i = 1'b1;
      @(posedge clk_i);
      #1;
      wait_done(lat, yz);
      check("ignore_lat", 32'(lat + 3), ref_lat(7));
      check("ignore_y", 32'(bus.y_bo), 32'd343);
      @(posedge clk_i);
      #1;
      bus.start_i = 1'b0;
      check("ignore_accept", 32'(bus.busy_o), 32'd1);
      wait_done(lat, yz);
      check("second_lat", 32'(lat), ref_lat(9));
      check("second_y", 32'(bus.y_bo), 32'd729);

      // Reset mid-computation discards the operation.
      start_op(8'd200);
      bus.start_i = 1'b0;
      repeat (5) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("midrst_busy", 32'(bus.busy_o), 32'd0);
      check("midrst_y", 32'(bus.y_bo), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      do_op(8'd2, "after_rst");

      // Start held high: back-to-back acceptances.
      start_op(8'd10);
      k1 = cyc;
      wait_done(lat, yz);
      check("b2b_y10", 32'(bus.y_bo), 32'd1000);
      bus.a_bi = 8'd11;
      @(posedge clk_i);
      #1;
      k2 = cyc;
      bus.start_i = 1'b0;
      check("b2b_accept", 32'(bus.busy_o), 32'd1);
      check("b2b_gap", 32'(k2 - k1), ref_lat(10) + 32'd1);
      wait_done(lat, yz);
      check("b2b_y11", 32'(bus.y_bo), 32'd1331);

      for (int a = 0; a < 256; a++) do_op(8'(a), "sweep");

      for (int i = 0; i < 24; i++) begin
         ra = 8'($urandom_range(0, 255));
         do_op(ra, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
